mdu_alu_seq: RTL and testbench
==============================

// Module: mdu_alu_seq
// PURPOSE
//  Iterative 16-bit multiply/divide sequencer that time-shares the execute-stage ALU.
//  - Accepts one MUL/DIV request at a time.
//  - Drives ALU controls/operands each cycle (add, subtract, negate) and consumes ALU Out/CF.
//  - Returns a 32-bit product or a quotient/remainder pair.
//  - Sits beside EX; the pipeline stalls on busy and grants the ALU via alu_gnt.
// PARAMETERS
//  WIDTH     16  operand/ALU width; the 5-bit iteration count assumes 16
//  ALU_OPW    4  width of the ALU Oper field
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      request; sampled only in IDLE
//  op_div     in   1      0=MUL, 1=DIV
//  op_sign    in   1      1=signed (two's complement) operands
//  opA        in   16     multiplicand / dividend
//  opB        in   16     multiplier / divisor
//  flush      in   1      synchronous abort to IDLE; no done is produced
//  alu_gnt    in   1      ALU owned this cycle; ALU-using states advance only when 1
//  alu_out    in   16     ALU result
//  alu_cf     in   1      ALU carry-out (1 = no borrow on subtract)
//  alu_req    out  1      high in every ALU-using state
//  alu_oper   out  4      ADD = 4'b0000 in every state
//  alu_ina    out  16     ALU InA
//  alu_inb    out  16     ALU InB
//  alu_cin    out  1      ALU Cin
//  alu_inva   out  1      ALU invA
//  alu_invb   out  1      ALU invB
//  busy       out  1      high in every state except IDLE
//  done       out  1      one-cycle pulse in DONE; results valid in that cycle
//  res_lo     out  16     MUL: product[15:0]; DIV: quotient
//  res_hi     out  16     MUL: product[31:16]; DIV: remainder
//  err        out  1      DIV by zero, or DIV while disabled; valid with done
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, including alu_req and all alu_* fields.
//  FSM: IDLE -> NEGA? -> NEGB? -> ITER x16 -> FIXLO? -> FIXHI? -> DONE -> IDLE.
//  - Each ? state is taken only when needed; DONE lasts exactly one cycle.
//  - IDLE: start=1 latches opA, opB, op_div and op_sign; iteration counter cnt=0.
//  - Operand signs sA/sB = MSB & op_sign.
//  - start while busy is ignored.
//  NEGA/NEGB: |x| = ~x + 1. Drive ina=x, inva=1, inb=0, cin=1; latch alu_out.
//  MUL ITER: P = {hi,lo}, hi=0, lo=|B|, M=|A|.
//  - lo[0]=1: ina=hi, inb=M; {hi,lo} <= {cf,out,lo[15:1]}.
//  - lo[0]=0: {hi,lo} <= {1'b0,hi,lo[15:1]}.
//  DIV ITER (restoring): R=hi=0, Q=lo=|A|, D=|B|. Shift {R,Q} left 1; let msb = bit shifted out of R.
//  - ALU computes R'-D: invb=1, cin=1.
//  - If cf|msb: R <= out and Q[0] <= 1.
//  - Otherwise R <= R' and Q[0] <= 0.
//  cnt increments per granted ITER cycle; leave ITER when cnt==15.
//  Fixup:
//  - MUL with sA^sB: FIXLO negates lo, and the ALU cf is latched. FIXHI computes ~hi + latched cf (inb=0).
//  - DIV: FIXLO if sA^sB, using cin=1. FIXHI if sA, using cin=1; remainder takes the dividend's sign.
//  Latency, unsigned with alu_gnt=1: done is high in cycle t+17 after the start edge t.
//  - Each NEG/FIX state adds 1 cycle.
//  - Each cycle with alu_gnt=0 in an ALU state adds 1 cycle; the datapath holds.
//  DIV with opB==0: skip straight to DONE (done at t+1). Results: err=1, res_lo=16'hFFFF, res_hi=opA.
//  res_lo, res_hi and err hold their values until the next start is accepted; they are cleared only by reset.
//  flush has priority over alu_gnt: state goes to IDLE next edge, done stays 0, res_* unchanged.
//  rst_n low mid-operation: everything clears immediately; no done is produced.
//  alu_req is deasserted in IDLE and DONE. alu_* outputs are 0 whenever alu_req=0.
// CONFIGURATION
//  MDU_ALU_SEQ_DIV_EN
//  - Defined: DIV supported as above.
//  - Undefined: an op_div=1 request goes IDLE->DONE with err=1 and res_lo=res_hi=0. The DIV datapath is not synthesised.
// STRUCTURE
//  Package mdu_pkg:
//  - State encoding localparams (IDLE, NEGA, NEGB, ITER, FIXLO, FIXHI, DONE).
//  - ALU_OP_ADD=4'b0000.
//  - MDU_OP_MUL/MDU_OP_DIV.
//  Single module: FSM, 5-bit counter and {hi,lo} shift register inline. No sub-module is needed.
// TESTING
//  1. Unsigned MUL 0x1234*0x0010, gnt=1 -> res_hi=0x0001, res_lo=0x2340, done at t+17.
//  2. Signed MUL 0xFFFD*0x0005 (-3*5) -> {res_hi,res_lo}=0xFFFF_FFF1, err=0.
//  3. Signed DIV 0xFFF9/0x0002 (-7/2) -> res_lo=0xFFFD, res_hi=0xFFFF; unsigned 0xFFFF/0x0001 -> 0xFFFF r 0.
//  4. DIV 0x0042/0x0000 -> done at t+1, err=1, res_lo=0xFFFF, res_hi=0x0042.
//  5. alu_gnt=0 for 5 cycles mid-ITER, plus start pulsed while busy -> case 1 result, done at t+22, second start ignored.
//  6. rst_n low mid-ITER -> outputs 0 asynchronously. flush mid-ITER -> IDLE next cycle, no done, res_* unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared state encoding and opcode constants for the iterative multiply/divide sequencer.
package mdu_pkg;

  localparam logic [3:0] ALU_OP_ADD = 4'b0000;

  localparam logic MDU_OP_MUL = 1'b0;
  localparam logic MDU_OP_DIV = 1'b1;

  localparam int MDU_CNT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_NEGA  = 3'd1,
    ST_NEGB  = 3'd2,
    ST_ITER  = 3'd3,
    ST_FIXLO = 3'd4,
    ST_FIXHI = 3'd5,
    ST_DONE  = 3'd6
  } mdu_state_e;

endpackage

// File: rtl/mdu_alu_seq.sv
// Iterative 16-bit MUL/DIV sequencer that borrows the EX-stage ALU one add per cycle.
// Divide support (restoring datapath, divide-by-zero handling) exists only with MDU_ALU_SEQ_DIV_EN defined.
module mdu_alu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ALU_OPW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               op_div,
  input  logic               op_sign,
  input  logic [WIDTH-1:0]   opA,
  input  logic [WIDTH-1:0]   opB,
  input  logic               flush,
  input  logic               alu_gnt,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_cf,
  output logic               alu_req,
  output logic [ALU_OPW-1:0] alu_oper,
  output logic [WIDTH-1:0]   alu_ina,
  output logic [WIDTH-1:0]   alu_inb,
  output logic               alu_cin,
  output logic               alu_inva,
  output logic               alu_invb,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   res_lo,
  output logic [WIDTH-1:0]   res_hi,
  output logic               err
);

`ifdef MDU_ALU_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  mdu_state_e           state_q, state_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic                 div_q, div_d;
  logic                 sa_q, sa_d;
  logic                 sb_q, sb_d;
  logic                 cf_q, cf_d;
  logic [WIDTH-1:0]     res_lo_q, res_lo_d;
  logic [WIDTH-1:0]     res_hi_q, res_hi_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 req_q, req_d;
  logic [WIDTH-1:0]     ina_q, ina_d;
  logic [WIDTH-1:0]     inb_q, inb_d;
  logic                 cin_q, cin_d;
  logic                 inva_q, inva_d;
  logic                 invb_q, invb_d;
  logic                 err_take;
  logic                 need_lo;
  logic                 need_hi;

`ifdef MDU_ALU_SEQ_DIV_EN
  logic [WIDTH-1:0] r_shift;
`endif

  // MUL negates the whole product on a sign mismatch; DIV gives the remainder the dividend's sign.
  assign need_lo = sa_q ^ sb_q;
  assign need_hi = div_q ? sa_q : (sa_q ^ sb_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    div_d    = div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cf_d     = cf_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    err_d    = err_q;
    err_take = 1'b0;
`ifdef MDU_ALU_SEQ_DIV_EN
    r_shift  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          div_d = (op_div == MDU_OP_DIV) && DIV_EN;
          sa_d  = op_sign & opA[WIDTH-1];
          sb_d  = op_sign & opB[WIDTH-1];
          cnt_d = '0;
          hi_d  = '0;
          // MUL shifts the multiplier through lo; DIV shifts the dividend through lo.
          lo_d  = (op_div == MDU_OP_DIV) ? opA : opB;
          m_d   = (op_div == MDU_OP_DIV) ? opB : opA;
          if ((op_div == MDU_OP_DIV) && (!DIV_EN || (opB == '0))) begin
            err_take = 1'b1;
            hi_d     = DIV_EN ? opA : '0;
            lo_d     = DIV_EN ? '1 : '0;
            state_d  = ST_DONE;
          end else if (sa_d) begin
            state_d = ST_NEGA;
          end else if (sb_d) begin
            state_d = ST_NEGB;
          end else begin
            state_d = ST_ITER;
          end
        end
      end

      ST_NEGA: begin
        if (alu_gnt) begin
          if (div_q) lo_d = alu_out;
          else       m_d  = alu_out;
          state_d = sb_q ? ST_NEGB : ST_ITER;
        end
      end

      ST_NEGB: begin
        if (alu_gnt) begin
          if (div_q) m_d  = alu_out;
          else       lo_d = alu_out;
          state_d = ST_ITER;
        end
      end

      ST_ITER: begin
        if (alu_gnt) begin
          cnt_d = cnt_q + 1'b1;
`ifdef MDU_ALU_SEQ_DIV_EN
          if (div_q) begin
            if (alu_cf | hi_q[WIDTH-1]) begin
              hi_d = alu_out;
              lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
              hi_d = r_shift;
              lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
          end else
`endif
          begin
            if (lo_q[0]) {hi_d, lo_d} = {alu_cf, alu_out, lo_q[WIDTH-1:1]};
            else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
          end
          if (cnt_q == MDU_CNT_W'(WIDTH - 1)) begin
            if (need_lo)      state_d = ST_FIXLO;
            else if (need_hi) state_d = ST_FIXHI;
            else              state_d = ST_DONE;
          end
        end
      end

      ST_FIXLO: begin
        if (alu_gnt) begin
          lo_d    = alu_out;
          cf_d    = alu_cf;
          state_d = need_hi ? ST_FIXHI : ST_DONE;
        end
      end

      ST_FIXHI: begin
        if (alu_gnt) begin
          hi_d    = alu_out;
          state_d = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    if (flush) state_d = ST_IDLE;

    // Results are captured only on entry to DONE, so a flushed run leaves them untouched.
    if (state_d == ST_DONE) begin
      res_lo_d = lo_d;
      res_hi_d = hi_d;
      err_d    = err_take;
    end

    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  // ALU controls are registered, so they are derived from the state and datapath of the next cycle.
  always_comb begin
    req_d  = 1'b0;
    ina_d  = '0;
    inb_d  = '0;
    cin_d  = 1'b0;
    inva_d = 1'b0;
    invb_d = 1'b0;

    case (state_d)
      ST_NEGA: begin
        req_d  = 1'b1;
        ina_d  = div_d ? lo_d : m_d;
        inva_d = 1'b1;
        cin_d  = 1'b1;
      end

      ST_NEGB: begin
        req_d  = 1'b1;
        ina_d  = div_d ? m_d : lo_d;
        inva_d = 1'b1;
        cin_d  = 1'b1;
      end

      ST_ITER: begin
        req_d = 1'b1;
`ifdef MDU_ALU_SEQ_DIV_EN
        if (div_d) begin
          ina_d  = {hi_d[WIDTH-2:0], lo_d[WIDTH-1]};
          inb_d  = m_d;
          invb_d = 1'b1;
          cin_d  = 1'b1;
        end else
`endif
        begin
          ina_d = hi_d;
          inb_d = m_d;
        end
      end

      ST_FIXLO: begin
        req_d  = 1'b1;
        ina_d  = lo_d;
        inva_d = 1'b1;
        cin_d  = 1'b1;
      end

      ST_FIXHI: begin
        req_d  = 1'b1;
        ina_d  = hi_d;
        inva_d = 1'b1;
        cin_d  = div_d ? 1'b1 : cf_d;
      end

      default: req_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      div_q    <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      cf_q     <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      req_q    <= 1'b0;
      ina_q    <= '0;
      inb_q    <= '0;
      cin_q    <= 1'b0;
      inva_q   <= 1'b0;
      invb_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      div_q    <= div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cf_q     <= cf_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      err_q    <= err_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      req_q    <= req_d;
      ina_q    <= ina_d;
      inb_q    <= inb_d;
      cin_q    <= cin_d;
      inva_q   <= inva_d;
      invb_q   <= invb_d;
    end
  end

  assign alu_req  = req_q;
  assign alu_oper = ALU_OPW'(ALU_OP_ADD);
  assign alu_ina  = ina_q;
  assign alu_inb  = inb_q;
  assign alu_cin  = cin_q;
  assign alu_inva = inva_q;
  assign alu_invb = invb_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign res_lo   = res_lo_q;
  assign res_hi   = res_hi_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mdu_alu_seq.sv
// Directed bench for mdu_alu_seq: arithmetic reference model plus literal result checks.
// Honours MDU_ALU_SEQ_DIV_EN the same way the design does.
module tb_mdu_alu_seq;

`ifdef MDU_ALU_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op_div = 1'b0;
  logic        op_sign = 1'b0;
  logic [15:0] opA = '0;
  logic [15:0] opB = '0;
  logic        flush = 1'b0;
  logic        alu_gnt = 1'b1;
  logic [15:0] alu_out;
  logic        alu_cf;
  logic        alu_req;
  logic [3:0]  alu_oper;
  logic [15:0] alu_ina;
  logic [15:0] alu_inb;
  logic        alu_cin;
  logic        alu_inva;
  logic        alu_invb;
  logic        busy;
  logic        done;
  logic [15:0] res_lo;
  logic [15:0] res_hi;
  logic        err;

  mdu_alu_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_div   (op_div),
    .op_sign  (op_sign),
    .opA      (opA),
    .opB      (opB),
    .flush    (flush),
    .alu_gnt  (alu_gnt),
    .alu_out  (alu_out),
    .alu_cf   (alu_cf),
    .alu_req  (alu_req),
    .alu_oper (alu_oper),
    .alu_ina  (alu_ina),
    .alu_inb  (alu_inb),
    .alu_cin  (alu_cin),
    .alu_inva (alu_inva),
    .alu_invb (alu_invb),
    .busy     (busy),
    .done     (done),
    .res_lo   (res_lo),
    .res_hi   (res_hi),
    .err      (err)
  );

  always #5 clk = ~clk;

  // The execute-stage ALU the sequencer borrows: a plain adder with optional operand inversion.
  logic [16:0] aluSum;
  assign aluSum  = {1'b0, (alu_inva ? ~alu_ina : alu_ina)} + {1'b0, (alu_invb ? ~alu_inb : alu_inb)} + {16'd0, alu_cin};
  assign alu_out = aluSum[15:0];
  assign alu_cf  = aluSum[16];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        err;
    int          doneCyc;
  } exp_t;

  exp_t expQ[$];
  exp_t cmpE;
  int   nCompared = 0;
  int   nMismatch = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, latency = 17 + one cycle per sign fix-up + stalls.
  function automatic exp_t model(input bit div, input bit sgn, input logic [15:0] a,
                                 input logic [15:0] b, input int stall);
    exp_t        r;
    int          sa;
    int          sb;
    longint      pa;
    longint      pb;
    longint      p;
    int          ia;
    int          ib;
    logic [63:0] pv;
    logic [31:0] qv;
    logic [31:0] rv;
    sa    = (sgn && a[15]) ? 1 : 0;
    sb    = (sgn && b[15]) ? 1 : 0;
    r.err = 1'b0;
    if (!div) begin
      pa        = sgn ? longint'($signed(a)) : longint'(a);
      pb        = sgn ? longint'($signed(b)) : longint'(b);
      p         = pa * pb;
      pv        = p;
      r.lo      = pv[15:0];
      r.hi      = pv[31:16];
      r.doneCyc = 17 + sa + sb + 2 * (sa ^ sb) + stall;
    end else if (!DIV_EN) begin
      r.lo      = 16'h0000;
      r.hi      = 16'h0000;
      r.err     = 1'b1;
      r.doneCyc = 1;
    end else if (b == 16'h0000) begin
      r.lo      = 16'hFFFF;
      r.hi      = a;
      r.err     = 1'b1;
      r.doneCyc = 1;
    end else begin
      ia        = sgn ? int'($signed(a)) : int'(a);
      ib        = sgn ? int'($signed(b)) : int'(b);
      qv        = ia / ib;
      rv        = ia % ib;
      r.lo      = qv[15:0];
      r.hi      = rv[15:0];
      r.doneCyc = 17 + sa + sb + (sa ^ sb) + sa + stall;
    end
    return r;
  endfunction

  // Compare process: ALU-interface sanity every cycle, results and latency on every done.
  always @(negedge clk) begin
    checkOutput("alu_oper", 64'(alu_oper), 64'h0);
    if (!alu_req)
      checkOutput("alu_fields_idle", 64'({alu_ina, alu_inb, alu_cin, alu_inva, alu_invb}), 64'h0);
    if (done) begin
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatch++;
        $display("[TB] FAIL unexpected_done: got done=1, required done=0 (cycle %0d)", cyc);
      end else begin
        cmpE = expQ.pop_front();
        checkOutput("model.res_lo", 64'(res_lo), 64'(cmpE.lo));
        checkOutput("model.res_hi", 64'(res_hi), 64'(cmpE.hi));
        checkOutput("model.err", 64'(err), 64'(cmpE.err));
        checkOutput("model.done_cycle", 64'(cyc), 64'(cmpE.doneCyc));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic waitDone(input string tag);
    for (int i = 0; i < 80; i++) begin
      if (expQ.size() == 0) break;
      tick();
    end
    if (expQ.size() != 0) begin
      nCompared++;
      nMismatch++;
      $display("[TB] FAIL %s.timeout: got no done, required done within 80 cycles", tag);
      expQ.delete();
    end
  endtask

  // Runs one request; a nonzero stallLen drops alu_gnt stallAt cycles in and pokes start while busy.
  task automatic applyStimulus(input string tag, input bit div, input bit sgn,
                               input logic [15:0] a, input logic [15:0] b,
                               input int stallAt, input int stallLen,
                               input logic [15:0] litHi, input logic [15:0] litLo, input logic litErr);
    exp_t e;
    e         = model(div, sgn, a, b, stallLen);
    e.doneCyc = cyc + e.doneCyc;
    expQ.push_back(e);
    op_div  = div;
    op_sign = sgn;
    opA     = a;
    opB     = b;
    start   = 1'b1;
    tick();
    start = 1'b0;
    if (stallLen > 0) begin
      repeat (stallAt) tick();
      alu_gnt = 1'b0;
      start   = 1'b1;
      opA     = 16'h0F0F;
      opB     = 16'h0003;
      op_div  = 1'b0;
      tick();
      start = 1'b0;
      repeat (stallLen - 1) tick();
      alu_gnt = 1'b1;
    end
    waitDone(tag);
    checkOutput({tag, ".res_hi"}, 64'(res_hi), 64'(litHi));
    checkOutput({tag, ".res_lo"}, 64'(res_lo), 64'(litLo));
    checkOutput({tag, ".err"}, 64'(err), 64'(litErr));
    tick();
  endtask

  // Starts an unsigned MUL, then kills it mid-ITER by reset or by flush; no done may follow.
  task automatic abortRun(input string tag, input bit useReset,
                          input logic [15:0] litHi, input logic [15:0] litLo, input logic litErr);
    op_div  = 1'b0;
    op_sign = 1'b0;
    opA     = 16'h0003;
    opB     = 16'h0003;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    if (useReset) begin
      rst_n = 1'b0;
      #1;
      checkOutput({tag, ".ctrl"}, 64'({busy, done, alu_req, err}), 64'h0);
      checkOutput({tag, ".alu"}, 64'({alu_ina, alu_inb, alu_cin, alu_inva, alu_invb}), 64'h0);
      checkOutput({tag, ".res"}, 64'({res_hi, res_lo}), 64'h0);
      tick();
      rst_n = 1'b1;
    end else begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput({tag, ".busy"}, 64'(busy), 64'h0);
      checkOutput({tag, ".done"}, 64'(done), 64'h0);
      checkOutput({tag, ".alu_req"}, 64'(alu_req), 64'h0);
    end
    repeat (25) tick();
    checkOutput({tag, ".res_hi_after"}, 64'(res_hi), 64'(litHi));
    checkOutput({tag, ".res_lo_after"}, 64'(res_lo), 64'(litLo));
    checkOutput({tag, ".err_after"}, 64'(err), 64'(litErr));
  endtask

  initial begin
    #1;
    checkOutput("reset.ctrl", 64'({busy, done, alu_req, err}), 64'h0);
    checkOutput("reset.alu", 64'({alu_ina, alu_inb, alu_cin, alu_inva, alu_invb}), 64'h0);
    checkOutput("reset.res", 64'({res_hi, res_lo}), 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    applyStimulus("mul_u_1234x10", 1'b0, 1'b0, 16'h1234, 16'h0010, 0, 0, 16'h0001, 16'h2340, 1'b0);
    applyStimulus("mul_s_m3x5", 1'b0, 1'b1, 16'hFFFD, 16'h0005, 0, 0, 16'hFFFF, 16'hFFF1, 1'b0);
    applyStimulus("mul_s_minxmin", 1'b0, 1'b1, 16'h8000, 16'h8000, 0, 0, 16'h4000, 16'h0000, 1'b0);
    applyStimulus("mul_s_maxxm1", 1'b0, 1'b1, 16'h7FFF, 16'hFFFF, 0, 0, 16'hFFFF, 16'h8001, 1'b0);
    applyStimulus("mul_u_ffffsq", 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 0, 0, 16'hFFFE, 16'h0001, 1'b0);
    applyStimulus("mul_s_0xm1", 1'b0, 1'b1, 16'h0000, 16'hFFFF, 0, 0, 16'h0000, 16'h0000, 1'b0);

`ifdef MDU_ALU_SEQ_DIV_EN
    applyStimulus("div_s_m7d2", 1'b1, 1'b1, 16'hFFF9, 16'h0002, 0, 0, 16'hFFFF, 16'hFFFD, 1'b0);
    applyStimulus("div_u_ffffd1", 1'b1, 1'b0, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 16'hFFFF, 1'b0);
    applyStimulus("div_s_100dm7", 1'b1, 1'b1, 16'h0064, 16'hFFF9, 0, 0, 16'h0002, 16'hFFF2, 1'b0);
    applyStimulus("div_s_mindm1", 1'b1, 1'b1, 16'h8000, 16'hFFFF, 0, 0, 16'h0000, 16'h8000, 1'b0);
    applyStimulus("div_u_by0", 1'b1, 1'b0, 16'h0042, 16'h0000, 0, 0, 16'h0042, 16'hFFFF, 1'b1);
`else
    applyStimulus("div_s_m7d2", 1'b1, 1'b1, 16'hFFF9, 16'h0002, 0, 0, 16'h0000, 16'h0000, 1'b1);
    applyStimulus("div_u_ffffd1", 1'b1, 1'b0, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 16'h0000, 1'b1);
    applyStimulus("div_u_by0", 1'b1, 1'b0, 16'h0042, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1'b1);
`endif

    applyStimulus("mul_u_stall", 1'b0, 1'b0, 16'h1234, 16'h0010, 4, 5, 16'h0001, 16'h2340, 1'b0);
    abortRun("flush_mid_iter", 1'b0, 16'h0001, 16'h2340, 1'b0);
    applyStimulus("mul_after_flush", 1'b0, 1'b1, 16'hFFFD, 16'h0005, 0, 0, 16'hFFFF, 16'hFFF1, 1'b0);
    abortRun("reset_mid_iter", 1'b1, 16'h0000, 16'h0000, 1'b0);
    applyStimulus("mul_after_reset", 1'b0, 1'b0, 16'h1234, 16'h0010, 0, 0, 16'h0001, 16'h2340, 1'b0);

    if (expQ.size() != 0) begin
      nCompared++;
      nMismatch++;
      $display("[TB] FAIL pending_results: got %0d outstanding, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
